// File: rtl/comparator_serial_ctrl_pkg.sv
// rtl/comparator_serial_ctrl_pkg.sv - shared state encodings, result codes and index-width helper
package comparator_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // {gt,eq,lt} ordering
  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/comparator_serial_ctrl_if.sv
// rtl/comparator_serial_ctrl_if.sv - request/result bundle of the serial comparator
interface comparator_serial_ctrl_if #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
);
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic          gt;
  logic          eq;
  logic          lt;
  logic [CW-1:0] bits_examined;

  modport master (
    output start, a, b,
    input  busy, done, gt, eq, lt, bits_examined
  );

  modport slave (
    input  start, a, b,
    output busy, done, gt, eq, lt, bits_examined
  );
endinterface

// File: rtl/comparator_bit.sv
// rtl/comparator_bit.sv - combinational 1-bit compare cell
module comparator_bit (
  input  logic x,
  input  logic y,
  output logic gt,
  output logic eq,
  output logic lt
);
  assign gt = x & ~y;
  assign eq = ~(x ^ y);
  assign lt = ~x & y;
endmodule

// File: rtl/comparator_serial_ctrl.sv
// rtl/comparator_serial_ctrl.sv - MSB-first bit-serial unsigned comparator sequencer
// Optional early exit on first differing bit: COMPARATOR_EARLY_EXIT_EN
module comparator_serial_ctrl
  import comparator_defs::*;
#(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic clk,
  input  logic rst,
  comparator_serial_ctrl_if.slave bus
);
  localparam int IW = idx_width(W);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_bits;
  logic          r_dec_gt;
  logic          r_dec_lt;
  logic          r_gt;
  logic          r_eq;
  logic          r_lt;

  logic          w_bit_gt;
  logic          w_bit_eq;
  logic          w_bit_lt;
  logic          w_first;
  logic          w_dec_gt;
  logic          w_dec_lt;
  logic          w_last;
  logic          w_accept;
  logic [2:0]    w_res;

  comparator_bit u_bit (
    .x  (r_a[r_idx]),
    .y  (r_b[r_idx]),
    .gt (w_bit_gt),
    .eq (w_bit_eq),
    .lt (w_bit_lt)
  );

  // Only the first differing bit decides; later bits cannot override it.
  assign w_first  = ~(r_dec_gt | r_dec_lt) & ~w_bit_eq;
  assign w_dec_gt = r_dec_gt | (w_first & w_bit_gt);
  assign w_dec_lt = r_dec_lt | (w_first & w_bit_lt);
  assign w_res    = w_dec_gt ? RES_GT : (w_dec_lt ? RES_LT : RES_EQ);

`ifdef COMPARATOR_EARLY_EXIT_EN
  assign w_last = (r_idx == '0) | w_first;
`else
  assign w_last = (r_idx == '0);
`endif

  assign w_accept = bus.start & ((r_state == ST_IDLE) | (r_state == ST_DONE));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = bus.start ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_bits   <= '0;
      r_dec_gt <= 1'b0;
      r_dec_lt <= 1'b0;
      r_gt     <= 1'b0;
      r_eq     <= 1'b0;
      r_lt     <= 1'b0;
    end else if (w_accept) begin
      r_a      <= bus.a;
      r_b      <= bus.b;
      r_idx    <= IW'(W - 1);
      r_cnt    <= '0;
      r_dec_gt <= 1'b0;
      r_dec_lt <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_cnt    <= r_cnt + CW'(1);
      r_dec_gt <= w_dec_gt;
      r_dec_lt <= w_dec_lt;
      if (w_last) begin
        {r_gt, r_eq, r_lt} <= w_res;
        r_bits             <= r_cnt + CW'(1);
      end else begin
        r_idx <= r_idx - IW'(1);
      end
    end
  end

  assign bus.busy          = (r_state == ST_RUN);
  assign bus.done          = (r_state == ST_DONE);
  assign bus.gt            = r_gt;
  assign bus.eq            = r_eq;
  assign bus.lt            = r_lt;
  assign bus.bits_examined = r_bits;
endmodule

// File: tb/tb_comparator_serial_ctrl.sv
// tb/tb_comparator_serial_ctrl.sv - directed self-checking bench for comparator_serial_ctrl
module tb_comparator_serial_ctrl;
`ifdef COMPARATOR_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  comparator_serial_ctrl_if #(.W(8), .CW(4)) bus ();

  comparator_serial_ctrl #(.W(8), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done; optionally injects a stray start.
  task automatic wait_done(input string tag, input int exp_m, input int inject_at);
    int n;
    int busy_cnt;
    n = 0;
    busy_cnt = 0;
    while (!bus.done && n < 40) begin
      if (bus.busy) busy_cnt++;
      if (n == inject_at) begin
        bus.start = 1'b1;
        bus.a     = 8'hFF;
      end
      step();
      bus.start = 1'b0;
      n++;
    end
    check({tag, "_latency"}, n, exp_m);
    check({tag, "_busy_cycles"}, busy_cnt, exp_m);
  endtask

  task automatic check_result(input string tag, input logic [2:0] exp_res, input int exp_m);
    check({tag, "_result"}, {bus.gt, bus.eq, bus.lt}, exp_res);
    check({tag, "_bits"}, bus.bits_examined, exp_m);
  endtask

  task automatic finish_op(input string tag);
    step();
    check({tag, "_done_pulse"}, bus.done, 1'b0);
    check({tag, "_idle"}, bus.busy, 1'b0);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] exp_res, input int exp_m);
    launch(a, b);
    wait_done(tag, exp_m, -1);
    check_result(tag, exp_res, exp_m);
    finish_op(tag);
  endtask

  initial begin
    int done_cnt;
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) step();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_result", {bus.gt, bus.eq, bus.lt}, 3'b000);
    check("rst_bits", bus.bits_examined, 0);
    rst = 1'b0;
    step();

    run_op("eq_a5", 8'hA5, 8'hA5, EQ, 8);
    run_op("gt_80", 8'h80, 8'h7F, GT, EE ? 1 : 8);
    run_op("lt_12", 8'h12, 8'h13, LT, 8);
    run_op("lt_00", 8'h00, 8'hFF, LT, EE ? 1 : 8);
    run_op("gt_ff", 8'hFF, 8'hFE, GT, 8);

    // stray start with new operand during RUN must not restart or alter the compare
    launch(8'h10, 8'h20);
    wait_done("ign", EE ? 3 : 8, 2);
    check_result("ign", LT, EE ? 3 : 8);
    finish_op("ign");

    // reset mid-RUN aborts without a done
    launch(8'h05, 8'h03);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_result", {bus.gt, bus.eq, bus.lt}, 3'b000);
    check("abort_bits", bus.bits_examined, 0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);

    // back-to-back: start held in the DONE cycle
    launch(8'h80, 8'h7F);
    wait_done("b2b1", EE ? 1 : 8, -1);
    check_result("b2b1", GT, EE ? 1 : 8);
    launch(8'h01, 8'h02);
    check("b2b_no_bubble", bus.busy, 1'b1);
    check_result("b2b_hold", GT, EE ? 1 : 8);
    step();
    check_result("b2b_hold_run", GT, EE ? 1 : 8);
    wait_done("b2b2", EE ? 6 : 7, -1);
    check_result("b2b2", LT, EE ? 7 : 8);
    finish_op("b2b2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/comparator_serial_ctrl.md
Name: comparator_serial_ctrl

Overview:
Sequencing controller that compares two W-bit unsigned operands MSB-first, one bit per clock, through a single shared 1-bit compare cell. It accepts a start pulse, latches the operands, walks the bit index down from W-1 to 0, and reports one-hot greater/equal/less with a done pulse. It serves as the multi-bit front end for the team's comparator blocks where area matters more than latency.

Parameters:
W, 8, operand width in bits (W >= 2)
CW, $clog2(W+1), width of bits_examined counter

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE or DONE
a  input  W  operand A, latched on accepted start
b  input  W  operand B, latched on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse, results valid
gt  output  1  A > B (registered, one-hot with eq/lt)
eq  output  1  A == B
lt  output  1  A < B
bits_examined  output  CW  bit positions compared in last operation

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; busy=0; done=0; gt=eq=lt=0; bits_examined=0; operand regs and index cleared. Reset overrides all other inputs, including mid-RUN. An aborted operation never produces done.
- States: IDLE, RUN, DONE; encoding comes from the shared package.
- IDLE: start=1 at edge k -> latch a,b into a_r,b_r; idx=W-1; cnt=0; move to RUN. start=0 -> stay.
- RUN, one bit per cycle:
  - Drive a_r[idx] and b_r[idx] into the compare cell.
  - Increment cnt.
  - Cell gt or lt -> record the decision.
  - Last cycle (idx==0, or decision made with the early-exit feature) -> move to DONE and register gt/eq/lt and bits_examined.
  - Otherwise idx decrements.
- RUN, other rules:
  - busy=1 throughout RUN.
  - start and changes on a/b are ignored.
- Equality: eq=1 only if all W bit pairs match.
- One-hot: after the first done, exactly one of gt/eq/lt is 1.
- DONE: done=1 for exactly one cycle. Next edge: start=1 -> accept as in IDLE and go to RUN (back-to-back, no idle bubble). Otherwise go to IDLE.
- Result hold: gt/eq/lt and bits_examined hold until the next DONE entry. They do not clear on a new start.
- Latency: start sampled at edge k; done is high in the cycle after edge k+m, where m = bits_examined.
  - Without the optional feature, m=W always.
  - With the feature, m = W - i, where i is the highest differing bit index (m=W when operands are equal).
- Arithmetic: unsigned only. idx is decremented modulo-free and never wraps below 0, because the transition to DONE occurs at idx==0.

Optional Feature:
COMPARATOR_EARLY_EXIT_EN
- Defined: RUN goes to DONE in the same cycle the first differing bit is found; bits_examined = W - i.
- Undefined: RUN always runs W cycles. The first difference is sticky and later bits are ignored. bits_examined=W; timing is constant and data-independent.

Decomposition:
- Shared package/header comparator_defs: state encodings, result codes, index-width function.
  - State encodings: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Result codes: RES_GT=3'b100, RES_EQ=3'b010, RES_LT=3'b001, matching the team's {gt,eq,lt} ordering.
- One sub-module, comparator_bit: purely combinational 1-bit cell.
  - Inputs: x, y.
  - Outputs: gt=x&~y, eq=~(x^y), lt=~x&y.
  - Instantiated once; the controller owns all sequencing.

Test Plan:
- a=8'hA5, b=8'hA5, start at edge k -> done in cycle after k+8; eq=1, gt=lt=0; bits_examined=8; busy high for 8 cycles.
- a=8'h80, b=8'h7F -> gt=1.
  - Feature on: done after k+1, bits_examined=1.
  - Feature off: done after k+8, bits_examined=8.
- a=8'h12, b=8'h13 -> lt=1, bits_examined=8 in both modes (difference at bit 0).
- a=8'h10, b=8'h20 started; at cycle 3 drive start=1 with a=8'hFF -> ignored; result lt=1 for the original operands, single done pulse.
- Start 8'h05 vs 8'h03, assert rst for one cycle at cycle 4 -> next cycle: busy=0, done=0, gt=eq=lt=0, bits_examined=0; no done afterwards without a new start.
- Back-to-back: start held high in the DONE cycle with a=8'h01, b=8'h02 -> immediate RUN, no IDLE cycle.
  - First result stays on the outputs until the second DONE.
  - Second done reports lt=1.
